// File: rtl/idex_stage.sv
// ID/EX pipeline register with load-use hazard detection and one-cycle bubble insertion.
// Optional performance counters are enabled by defining IDEX_PERF_CNT_EN.
module idex_stage #(
    parameter int XLEN   = 32,
    parameter int PERF_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    output logic            id_ready,
    input  logic [XLEN-1:0] id_pc,
    input  logic [31:0]     id_inst,
    input  logic [XLEN-1:0] id_imm,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic            id_rs1able,
    input  logic            id_rs2able,
    input  logic [4:0]      id_rd,
    input  logic            id_wreg,
    input  logic            id_memread,
    input  logic            flush,
    input  logic            ex_ready,
    output logic            idex_valid,
    output logic [XLEN-1:0] idexPc,
    output logic [31:0]     idexInst,
    output logic [XLEN-1:0] idexImm,
    output logic [4:0]      idexRs1,
    output logic [4:0]      idexRs2,
    output logic            idexRs1able,
    output logic            idexRs2able,
    output logic [4:0]      idexRd,
    output logic            idexWreg,
    output logic            idexMemread,
    output logic            loadused
`ifdef IDEX_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0] perf_stall,
    output logic [PERF_W-1:0] perf_flush
`endif
);

    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_inst;
    logic [XLEN-1:0] r_imm;
    logic [4:0]      r_rs1;
    logic [4:0]      r_rs2;
    logic            r_rs1able;
    logic            r_rs2able;
    logic [4:0]      r_rd;
    logic            r_wreg;
    logic            r_memread;

    logic w_advance;
    logic w_loadused;
    logic w_bubble;

    assign w_advance  = ~r_valid | ex_ready;
    assign w_loadused = id_valid & r_valid & r_memread & (r_rd != 5'd0) &
                        (((r_rd == id_rs1) & id_rs1able) | ((r_rd == id_rs2) & id_rs2able));
    assign w_bubble   = flush | w_loadused | ~id_valid;

    assign id_ready = flush | (w_advance & ~w_loadused);
    assign loadused = w_loadused;

    // Without advance the register holds; a flush then only drops ID through id_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_pc      <= '0;
            r_inst    <= '0;
            r_imm     <= '0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_rs1able <= 1'b0;
            r_rs2able <= 1'b0;
            r_rd      <= '0;
            r_wreg    <= 1'b0;
            r_memread <= 1'b0;
        end else if (w_advance) begin
            if (w_bubble) begin
                r_valid   <= 1'b0;
                r_pc      <= '0;
                r_inst    <= '0;
                r_imm     <= '0;
                r_rs1     <= '0;
                r_rs2     <= '0;
                r_rs1able <= 1'b0;
                r_rs2able <= 1'b0;
                r_rd      <= '0;
                r_wreg    <= 1'b0;
                r_memread <= 1'b0;
            end else begin
                r_valid   <= 1'b1;
                r_pc      <= id_pc;
                r_inst    <= id_inst;
                r_imm     <= id_imm;
                r_rs1     <= id_rs1;
                r_rs2     <= id_rs2;
                r_rs1able <= id_rs1able;
                r_rs2able <= id_rs2able;
                r_rd      <= id_rd;
                r_wreg    <= id_wreg;
                r_memread <= id_memread;
            end
        end
    end

    assign idex_valid  = r_valid;
    assign idexPc      = r_pc;
    assign idexInst    = r_inst;
    assign idexImm     = r_imm;
    assign idexRs1     = r_rs1;
    assign idexRs2     = r_rs2;
    assign idexRs1able = r_rs1able;
    assign idexRs2able = r_rs2able;
    assign idexRd      = r_rd;
    assign idexWreg    = r_wreg;
    assign idexMemread = r_memread;

`ifdef IDEX_PERF_CNT_EN
    logic [PERF_W-1:0] r_perf_stall;
    logic [PERF_W-1:0] r_perf_flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_stall <= '0;
            r_perf_flush <= '0;
        end else begin
            if (w_loadused & w_advance & ~flush)
                r_perf_stall <= r_perf_stall + 1'b1;
            if (flush & id_valid)
                r_perf_flush <= r_perf_flush + 1'b1;
        end
    end

    assign perf_stall = r_perf_stall;
    assign perf_flush = r_perf_flush;
`else
    // PERF_W only sizes the counters; keep it referenced when they are compiled out.
    if (PERF_W < 1) begin : g_perf_w_invalid
    end
`endif

endmodule

// File: tb/tb_idex_stage.sv
// Self-checking bench for idex_stage: directed scenarios plus randomized traffic
// against a transaction-level model of the ID/EX slot.
module tb_idex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_ready;
    logic [31:0] id_pc, id_inst, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_rs1able, id_rs2able, id_wreg, id_memread;
    logic        flush, ex_ready;
    logic        idex_valid;
    logic [31:0] idexPc, idexInst, idexImm;
    logic [4:0]  idexRs1, idexRs2, idexRd;
    logic        idexRs1able, idexRs2able, idexWreg, idexMemread;
    logic        loadused;
`ifdef IDEX_PERF_CNT_EN
    logic [31:0] perf_stall, perf_flush;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        a1;
        logic        a2;
        logic [4:0]  rd;
        logic        wreg;
        logic        mr;
    } slot_t;

    idex_stage #(.XLEN(32), .PERF_W(32)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_pc(id_pc), .id_inst(id_inst), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1able(id_rs1able), .id_rs2able(id_rs2able),
        .id_rd(id_rd), .id_wreg(id_wreg), .id_memread(id_memread),
        .flush(flush), .ex_ready(ex_ready),
        .idex_valid(idex_valid), .idexPc(idexPc), .idexInst(idexInst), .idexImm(idexImm),
        .idexRs1(idexRs1), .idexRs2(idexRs2),
        .idexRs1able(idexRs1able), .idexRs2able(idexRs2able),
        .idexRd(idexRd), .idexWreg(idexWreg), .idexMemread(idexMemread),
        .loadused(loadused)
`ifdef IDEX_PERF_CNT_EN
        , .perf_stall(perf_stall), .perf_flush(perf_flush)
`endif
    );

    always #5 clk = ~clk;

    function automatic slot_t observed();
        return {idex_valid, idexPc, idexInst, idexImm, idexRs1, idexRs2,
                idexRs1able, idexRs2able, idexRd, idexWreg, idexMemread};
    endfunction

    // An ID instruction must wait if it reads the register a load in EX is about to produce.
    function automatic bit must_wait(slot_t ex, bit v, logic [4:0] r1, logic [4:0] r2, bit a1, bit a2);
        bit reads_rd;
        reads_rd = (a1 && r1 == ex.rd) || (a2 && r2 == ex.rd);
        return v && ex.v && ex.mr && ex.rd != 0 && reads_rd;
    endfunction

    task automatic set_id(input bit v, input logic [31:0] pc, input logic [4:0] rs1, input bit a1,
                          input logic [4:0] rs2, input bit a2, input logic [4:0] rd,
                          input bit wr, input bit mr);
        id_valid = v; id_pc = pc; id_inst = pc ^ 32'h00c0ffee; id_imm = ~pc;
        id_rs1 = rs1; id_rs1able = a1; id_rs2 = rs2; id_rs2able = a2;
        id_rd = rd; id_wreg = wr; id_memread = mr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        checks++;
        if (idex_valid !== 1'b0 || idexWreg !== 1'b0 || loadused !== 1'b0 || observed() !== '0) begin
            errors++;
            $display("FAIL reset_state: got %h want 0 (loadused=%b)", observed(), loadused);
        end
    endtask

    task automatic test_passthrough();
        flush = 0; ex_ready = 1;
        set_id(1, 32'h80000004, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0);
        #1;
        checks++;
        if (id_ready !== 1'b1) begin errors++; $display("FAIL pass_ready: got %b want 1", id_ready); end
        tick();
        checks++;
        if (idexPc !== 32'h80000004 || idexRd !== 5'd5 || idex_valid !== 1'b1 || idexWreg !== 1'b1) begin
            errors++;
            $display("FAIL pass_capture: got pc=%h rd=%0d v=%b w=%b want pc=80000004 rd=5 v=1 w=1",
                     idexPc, idexRd, idex_valid, idexWreg);
        end
    endtask

    task automatic test_load_use();
        flush = 0; ex_ready = 1;
        set_id(1, 32'h00001000, 5'd2, 1, 5'd0, 0, 5'd6, 1, 1);  // lw x6
        tick();
        set_id(1, 32'h00001004, 5'd6, 1, 5'd1, 1, 5'd7, 1, 0);  // add x7,x6,x1
        #1;
        checks++;
        if (loadused !== 1'b1 || id_ready !== 1'b0) begin
            errors++; $display("FAIL lu_detect: got lu=%b rdy=%b want lu=1 rdy=0", loadused, id_ready);
        end
        tick();
        checks++;
        if (idex_valid !== 1'b0 || idexWreg !== 1'b0 || idexMemread !== 1'b0 || loadused !== 1'b0 || id_ready !== 1'b1) begin
            errors++;
            $display("FAIL lu_bubble: got v=%b w=%b mr=%b lu=%b rdy=%b want 0 0 0 0 1",
                     idex_valid, idexWreg, idexMemread, loadused, id_ready);
        end
        tick();
        checks++;
        if (idex_valid !== 1'b1 || idexPc !== 32'h00001004 || idexRd !== 5'd7) begin
            errors++; $display("FAIL lu_capture: got v=%b pc=%h rd=%0d want 1 00001004 7", idex_valid, idexPc, idexRd);
        end
    endtask

    task automatic test_x0_able();
        flush = 0; ex_ready = 1;
        set_id(1, 32'h00002000, 5'd3, 1, 5'd0, 0, 5'd0, 1, 1);  // lw x0
        tick();
        set_id(1, 32'h00002004, 5'd0, 1, 5'd0, 1, 5'd8, 1, 0);
        #1;
        checks++;
        if (loadused !== 1'b0 || id_ready !== 1'b1) begin
            errors++; $display("FAIL x0_nohaz: got lu=%b rdy=%b want 0 1", loadused, id_ready);
        end
        tick();
        set_id(1, 32'h00002008, 5'd3, 1, 5'd0, 0, 5'd6, 1, 1);  // lw x6
        tick();
        set_id(1, 32'h0000200c, 5'd3, 1, 5'd6, 0, 5'd9, 1, 0);  // rs2=x6 not read
        #1;
        checks++;
        if (loadused !== 1'b0 || id_ready !== 1'b1) begin
            errors++; $display("FAIL able_nohaz: got lu=%b rdy=%b want 0 1", loadused, id_ready);
        end
        tick();
        checks++;
        if (idex_valid !== 1'b1 || idexPc !== 32'h0000200c) begin
            errors++; $display("FAIL able_capture: got v=%b pc=%h want 1 0000200c", idex_valid, idexPc);
        end
    endtask

    task automatic test_backpressure_flush();
        slot_t held;
        flush = 0; ex_ready = 1;
        set_id(1, 32'h00003000, 5'd4, 1, 5'd5, 1, 5'd10, 1, 0);
        tick();
        held = observed();
        ex_ready = 0; flush = 1;
        set_id(1, 32'h00003004, 5'd10, 1, 5'd1, 1, 5'd11, 1, 0);
        #1;
        checks++;
        if (id_ready !== 1'b1) begin errors++; $display("FAIL bp_flush_ready: got %b want 1", id_ready); end
        tick();
        checks++;
        if (observed() !== held || idexPc !== 32'h00003000) begin
            errors++; $display("FAIL bp_flush_hold: got %h want %h", observed(), held);
        end
        ex_ready = 1; flush = 0; id_valid = 0;
        tick();
        checks++;
        if (observed() !== '0) begin errors++; $display("FAIL bp_bubble: got %h want 0", observed()); end
    endtask

    task automatic test_reset_async();
        flush = 0; ex_ready = 1;
        set_id(1, 32'h00004000, 5'd1, 1, 5'd0, 0, 5'd12, 1, 1);
        tick();
        set_id(1, 32'h00004004, 5'd12, 1, 5'd0, 0, 5'd13, 1, 0);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (idex_valid !== 1'b0 || idexWreg !== 1'b0 || loadused !== 1'b0 || observed() !== '0) begin
            errors++;
            $display("FAIL async_reset: got v=%b w=%b lu=%b slot=%h want all 0", idex_valid, idexWreg, loadused, observed());
        end
        #1;
        rst = 1'b0;
        tick();
    endtask

`ifdef IDEX_PERF_CNT_EN
    task automatic test_perf();
        pulse_reset();
        flush = 0; ex_ready = 1;
        for (int i = 0; i < 3; i++) begin
            set_id(1, 32'h5000 + i * 16, 5'd1, 1, 5'd0, 0, 5'd6, 1, 1);
            tick();
            set_id(1, 32'h5004 + i * 16, 5'd2, 1, 5'd6, 1, 5'd7, 1, 0);
            tick();
            tick();
        end
        flush = 1;
        tick();
        tick();
        flush = 0; id_valid = 0;
        tick();
        checks++;
        if (perf_stall !== 32'd3 || perf_flush !== 32'd2) begin
            errors++; $display("FAIL perf_counts: got stall=%0d flush=%0d want 3 2", perf_stall, perf_flush);
        end
    endtask
`endif

    task automatic test_random();
        slot_t m;
        bit    exp_lu, exp_rdy, adv;
        int    lu_err, rdy_err, slot_err;
        int unsigned st_cnt, fl_cnt;
        lu_err = 0; rdy_err = 0; slot_err = 0; st_cnt = 0; fl_cnt = 0;
        pulse_reset();
        m = '0;
        for (int n = 0; n < 600; n++) begin
            ex_ready = ($urandom_range(0, 3) != 0);
            flush    = ($urandom_range(0, 9) == 0);
            set_id($urandom_range(0, 4) != 0, $urandom, 5'($urandom_range(0, 7)), 1'($urandom),
                   5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)),
                   1'($urandom), $urandom_range(0, 1) == 1);
            exp_lu  = must_wait(m, id_valid, id_rs1, id_rs2, id_rs1able, id_rs2able);
            adv     = !m.v || ex_ready;
            exp_rdy = flush || (adv && !exp_lu);
            #1;
            checks++;
            if (loadused !== exp_lu) begin
                errors++;
                if (lu_err++ < 5) $display("FAIL rnd_loadused[%0d]: got %b want %b", n, loadused, exp_lu);
            end
            checks++;
            if (id_ready !== exp_rdy) begin
                errors++;
                if (rdy_err++ < 5) $display("FAIL rnd_id_ready[%0d]: got %b want %b", n, id_ready, exp_rdy);
            end
            if (exp_lu && adv && !flush) st_cnt++;
            if (flush && id_valid) fl_cnt++;
            if (adv) begin
                if (flush || exp_lu || !id_valid) m = '0;
                else m = {1'b1, id_pc, id_inst, id_imm, id_rs1, id_rs2, id_rs1able, id_rs2able,
                          id_rd, id_wreg, id_memread};
            end
            tick();
            checks++;
            if (observed() !== m) begin
                errors++;
                if (slot_err++ < 5) $display("FAIL rnd_slot[%0d]: got %h want %h", n, observed(), m);
            end
        end
`ifdef IDEX_PERF_CNT_EN
        checks++;
        if (perf_stall !== st_cnt || perf_flush !== fl_cnt) begin
            errors++;
            $display("FAIL rnd_perf: got stall=%0d flush=%0d want %0d %0d", perf_stall, perf_flush, st_cnt, fl_cnt);
        end
`endif
    endtask

    initial begin
        rst = 1'b1; flush = 0; ex_ready = 0;
        set_id(0, '0, '0, 0, '0, 0, '0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        tick();
        test_reset();
        test_passthrough();
        test_load_use();
        test_x0_able();
        test_backpressure_flush();
        test_reset_async();
`ifdef IDEX_PERF_CNT_EN
        test_perf();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
